alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL provide: Clk  input  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL provide: Rst  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL provide: ReqA, ReqB  input  1 each  level request from requester A / B.
REQ-004 The block SHALL provide: XA, YA, XB, YB  input  5 each  operands of requester A / B.
REQ-005 The block SHALL provide: SA, SB  input  2 each  operation select of requester A / B.
REQ-006 The block SHALL provide: AluX, AluY  output  5 each, and AluS  output  2, driven to the shared combinational ALU.
REQ-007 The block SHALL provide: AluF  input  5, AluCout  input  1, AluOverflow  input  1, returned from the ALU.
REQ-008 The block SHALL provide: F  output  5, Cout  output  1, Overflow  output  1  registered result of the last completed operation.
REQ-009 The block SHALL provide: DoneA, DoneB  output  1 each  one-cycle completion pulse for requester A / B.
REQ-010 The block SHALL provide: Busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE, DONE; IDLE->ISSUE when ReqA|ReqB sampled high; ISSUE->DONE unconditionally; DONE->IDLE unconditionally.
REQ-012 On IDLE->ISSUE the block SHALL latch the winner's X, Y, S into the AluX/AluY/AluS registers and record the winner.
REQ-013 On ISSUE->DONE the block SHALL register AluF, AluCout, AluOverflow into F, Cout, Overflow.
REQ-014 In DONE the block SHALL assert exactly the winner's Done output for one cycle; the other Done SHALL stay low.
REQ-015 Latency SHALL be 3 rising edges from the edge sampling the request to the edge ending the DONE pulse; throughput SHALL be one operation per 3 cycles.
REQ-016 Requests SHALL be sampled only in IDLE; changes to Req/operands in ISSUE or DONE SHALL not affect the operation in flight.
REQ-017 A request withdrawn after grant SHALL still complete and pulse its Done.
REQ-018 A requester SHALL drop Req on the edge that samples its Done high; Req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-019 With a single requester active, that requester SHALL be granted.
REQ-020 F, Cout, Overflow, AluX, AluY, AluS SHALL hold their values between operations.
REQ-021 The block SHALL not modify operand or result bits; all arithmetic is performed by the external ALU.

Reset
REQ-022 Rst high SHALL immediately force state IDLE, all outputs to 0, and the last-grant pointer to B.
REQ-023 Rst asserted in ISSUE or DONE SHALL abort the operation with no Done pulse and no result update.
REQ-024 After Rst deasserts, the first IDLE sample SHALL arbitrate normally.

Configuration
REQ-025 With macro ALU_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last (pointer updated on each grant).
REQ-026 Without ALU_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to A (fixed priority) and the pointer SHALL not exist.

Verification
REQ-027 Reset, ReqA=1 only, XA=00111, YA=00011, SA=10, ALU model per S -> ISSUE AluX=00111 AluS=10; DONE DoneA=1, F=01010, Cout=0, Overflow=0, DoneB=0.
REQ-028 ReqB only, XB=01000, YB=01000, SB=10 -> DoneB pulse with F=10000, Overflow=1, Cout=0.
REQ-029 ReqA and ReqB both held high continuously from reset, RR defined -> grant order A, B, A, B; Done pulses every 3 cycles.
REQ-030 Same stimulus, RR undefined -> DoneA every 3 cycles, DoneB never asserted.
REQ-031 Rst pulsed during ISSUE of an A operation -> no DoneA, F=00000, Busy=0 next cycle; subsequent ReqA completes normally.
REQ-032 ReqA dropped and XA changed during ISSUE -> DoneA still pulses with result of originally latched operands.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter fronting a shared combinational ALU: IDLE -> ISSUE -> DONE per operation.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise A has fixed priority.
module alu_arbiter (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       ReqA,
    input  logic       ReqB,
    input  logic [4:0] XA,
    input  logic [4:0] YA,
    input  logic [4:0] XB,
    input  logic [4:0] YB,
    input  logic [1:0] SA,
    input  logic [1:0] SB,
    output logic [4:0] AluX,
    output logic [4:0] AluY,
    output logic [1:0] AluS,
    input  logic [4:0] AluF,
    input  logic       AluCout,
    input  logic       AluOverflow,
    output logic [4:0] F,
    output logic       Cout,
    output logic       Overflow,
    output logic       DoneA,
    output logic       DoneB,
    output logic       Busy
);

    localparam int unsigned DW = 5;
    localparam int unsigned SW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic          win_b;
    logic          grant_b_c;
    logic [DW-1:0] sel_x_c;
    logic [DW-1:0] sel_y_c;
    logic [SW-1:0] sel_s_c;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // last_b remembers the previous winner; on contention the other side wins.
    logic last_b;
    assign grant_b_c = ReqB & (~ReqA | ~last_b);
`else
    assign grant_b_c = ReqB & ~ReqA;
`endif

    always_comb begin
        sel_x_c = grant_b_c ? XB : XA;
        sel_y_c = grant_b_c ? YB : YA;
        sel_s_c = grant_b_c ? SB : SA;
    end

    // Sequencer: operands captured on grant, result captured on ISSUE -> DONE.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            win_b    <= 1'b0;
            AluX     <= '0;
            AluY     <= '0;
            AluS     <= '0;
            F        <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            DoneA    <= 1'b0;
            DoneB    <= 1'b0;
            Busy     <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_b   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ReqA | ReqB) begin
                        state <= ISSUE;
                        Busy  <= 1'b1;
                        win_b <= grant_b_c;
                        AluX  <= sel_x_c;
                        AluY  <= sel_y_c;
                        AluS  <= sel_s_c;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        last_b <= grant_b_c;
`endif
                    end
                end
                ISSUE: begin
                    state    <= DONE;
                    F        <= AluF;
                    Cout     <= AluCout;
                    Overflow <= AluOverflow;
                    DoneA    <= ~win_b;
                    DoneB    <= win_b;
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    DoneA <= 1'b0;
                    DoneB <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    DoneA <= 1'b0;
                    DoneB <= 1'b0;
                end
            endcase
        end
    end

endmodule
